// File: rtl/countdown_timer.sv
// Cook-time countdown: BCD MM:SS entry, one-second decrement per TICK_DIV clocks, optional add30 (TIMER_ADD30_EN).
// Latency: entry/add30/clear visible one cycle after the strobe; first decrement TICK_DIV cycles after mag_on rises from pre=0.
// Backpressure: none; strobes are sampled every cycle, and entry is ignored while mag_on is high.
module countdown_timer #(
   parameter int TICK_DIV = 100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clearn,
   input  logic       load_en,
   input  logic [3:0] digit,
   input  logic       mag_on,
`ifdef TIMER_ADD30_EN
   input  logic       add30,
`endif
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       timer_done,
   output logic       done_pulse
);

   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

   logic [PW-1:0] pre;
   logic          t_zero;
   logic          tick;
   logic          last_sec;
   logic [3:0]    d_mt, d_mo, d_st, d_so;

   assign t_zero     = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                       (sec_tens == 4'd0) && (sec_ones == 4'd0);
   assign timer_done = t_zero;
   assign tick       = mag_on && !t_zero && (pre == PRE_MAX);
   assign last_sec   = {min_tens, min_ones, sec_tens, sec_ones} == 16'h0001;

   // One-second BCD decrement with borrow chain; never evaluated at 00:00.
   always_comb begin
      d_mt = min_tens;
      d_mo = min_ones;
      d_st = sec_tens;
      d_so = sec_ones;
      if (sec_ones != 4'd0) begin
         d_so = sec_ones - 4'd1;
      end else begin
         d_so = 4'd9;
         if (sec_tens != 4'd0) begin
            d_st = sec_tens - 4'd1;
         end else begin
            d_st = 4'd5;
            if (min_ones != 4'd0) begin
               d_mo = min_ones - 4'd1;
            end else begin
               d_mo = 4'd9;
               d_mt = min_tens - 4'd1;
            end
         end
      end
   end

`ifdef TIMER_ADD30_EN
   logic [12:0] tot, sum;
   logic [6:0]  mins;
   logic [5:0]  secs;
   logic [3:0]  a_mt, a_mo, a_st, a_so;

   // Unnormalised seconds digits (e.g. 0:95) are folded into the total, then re-split.
   always_comb begin
      tot = 13'(min_tens) * 13'd600 + 13'(min_ones) * 13'd60 +
            13'(sec_tens) * 13'd10 + 13'(sec_ones);
      sum = tot + 13'd30;
      if (sum > 13'd5999) sum = 13'd5999;
      mins = 7'(sum / 13'd60);
      secs = 6'(sum % 13'd60);
      a_mt = 4'(mins / 7'd10);
      a_mo = 4'(mins % 7'd10);
      a_st = 4'(secs / 6'd10);
      a_so = 4'(secs % 6'd10);
   end
`endif

   always_ff @(posedge clk) begin
      done_pulse <= 1'b0;
      if (reset || !clearn) begin
         min_tens <= 4'd0;
         min_ones <= 4'd0;
         sec_tens <= 4'd0;
         sec_ones <= 4'd0;
         pre      <= '0;
      end
`ifdef TIMER_ADD30_EN
      else if (add30) begin
         min_tens <= a_mt;
         min_ones <= a_mo;
         sec_tens <= a_st;
         sec_ones <= a_so;
         // A pending tick is deferred, not lost: pre stays at PRE_MAX.
         if (t_zero)
            pre <= '0;
         else if (mag_on && !tick)
            pre <= pre + PW'(1);
      end
`endif
      else if (tick) begin
         min_tens   <= d_mt;
         min_ones   <= d_mo;
         sec_tens   <= d_st;
         sec_ones   <= d_so;
         pre        <= '0;
         done_pulse <= last_sec;
      end else begin
         if (t_zero)
            pre <= '0;
         else if (mag_on)
            pre <= pre + PW'(1);
         if (!mag_on && load_en && (digit <= 4'd9)) begin
            min_tens <= min_ones;
            min_ones <= sec_tens;
            sec_tens <= sec_ones;
            sec_ones <= digit;
         end
      end
   end

endmodule
